control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  sole clock; all state changes on rising edge.
REQ-002 clear  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 run  input  1  1 = fetch/execute; sampled only in IDLE and at T0 entry.
REQ-004 ir  input  32  IR contents; opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-005 mem_ready  input  1  memory read-data-valid; held high for at least one clock per read.
REQ-006 PCout, Zhighout, Zlowout, MDRout, Cout  output  1 each  bus-drive enables.
REQ-007 MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn  output  1 each  register load enables.
REQ-008 IncPC, Read  output  1 each  PC increment; MDR load-from-memory select.
REQ-009 reg_out, reg_in  output  16 each  one-hot R0-R15 bus-drive and load enables; all-zero when idle.
REQ-010 alu_op  output  5  ALU operation code.
REQ-011 busy, halted, illegal  output  1 each  status; illegal is a one-cycle pulse.
REQ-012 instr_count  output  16  count of completed instructions.

Function
REQ-013 States: IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT; only those listed per step assert signals, all others 0.
REQ-014 IDLE: no enables; run=1 -> T0, else stay.
REQ-015 T0: PCout, MARin, IncPC; -> T1.
REQ-016 T1: Read, MDRin; stay while mem_ready=0; mem_ready=1 -> T2.
REQ-017 T2: MDRout, IRin; -> T3. Decode uses ir from T3 onward.
REQ-018 R-type (opcode 5'b00011-5'b01100): T3 reg_out[Rb], Yin; T4 reg_out[Rc], alu_op=opcode, ZLowIn, ZHighIn; T5 Zlowout, reg_in[Ra]; end.
REQ-019 I-type (5'b01101-5'b01111): as REQ-018, except T4 asserts Cout in place of reg_out[Rc].
REQ-020 mul/div (5'b10000, 5'b10001): T3 reg_out[Ra], Yin; T4 reg_out[Rb], alu_op=opcode, ZLowIn, ZHighIn; T5 Zlowout, LOin; T6 Zhighout, HIin; end.
REQ-021 ld (5'b00000): T3 reg_out[Rb], Yin; T4 Cout, alu_op=5'b00011, ZLowIn; T5 Zlowout, MARin; T6 Read, MDRin, stay while mem_ready=0; T7 MDRout, reg_in[Ra]; end.
REQ-022 nop (5'b11010): T3 only, no enables; end.
REQ-023 halt (5'b11011): T3 -> HALT; HALT asserts halted=1 and no enables; exits only via clear.
REQ-024 Any other opcode: T3 pulses illegal=1, no enables; end (treated as nop).
REQ-025 "end": instr_count increments (wraps 16'hFFFF -> 0) on the same edge that leaves the last step; next state T0 if run=1, else IDLE.
REQ-026 run deasserted mid-instruction: current instruction completes in full; no abort.
REQ-027 busy=1 in every state except IDLE and HALT.
REQ-028 At most one bus-drive enable (including reg_out bits) asserted in any cycle; reg_in is one-hot or zero.
REQ-029 Halt does not increment instr_count.
REQ-030 Latency, mem_ready=1 immediately: R/I-type 6 clocks, mul/div 7, ld 8, nop 4.

Reset
REQ-031 clear=0 forces state IDLE, all enables 0, reg_out/reg_in/alu_op 0, busy/halted/illegal 0, instr_count 0 immediately, independent of clock.
REQ-032 Reset asserted in any state, including T1/T6 waits, abandons the instruction; no partial enables after assertion.
REQ-033 After clear returns high, first state change is IDLE -> T0 on the first rising edge with run=1.

Verification
REQ-034 add R1,R2,R3 (ir=32'h1891_8000), run=1, mem_ready=1 -> T3 reg_out=16'h0004 with Yin; T4 reg_out=16'h0008 with alu_op=5'b00011; T5 reg_in=16'h0002 with Zlowout; instr_count=1.
REQ-035 ld R4,0x10(R5) with mem_ready held 0 for 3 cycles in T6 -> Read and MDRin held 4 cycles; T7 reg_in=16'h0010 with MDRout; total 11 clocks.
REQ-036 mul R6,R7 (opcode 5'b10000) -> T5 LOin with Zlowout, T6 HIin with Zhighout, never both in one cycle.
REQ-037 halt then run held 1 for 20 clocks -> halted=1, busy=0, all enables 0, instr_count unchanged; clear pulse -> IDLE.
REQ-038 opcode 5'b11111 -> illegal high exactly one cycle in T3; instr_count increments; next fetch starts at T0.
REQ-039 clear driven 0 mid-clock during T4 -> enables and instr_count zero before next edge; run deasserted during an add -> instruction completes, then IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a simple bus-based CPU datapath.
// Steps a fetch (T0-T2) followed by an opcode-dependent execute sequence
// (T3-T7), driving one-hot bus-drive and register-load enables.
// Enables are decoded from the current step and the live ir, because ir
// only holds the new instruction once IRin has taken effect at T3.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        ZHighIn,
    output logic        ZLowIn,
    output logic        IncPC,
    output logic        Read,
    output logic [15:0] reg_out,
    output logic [15:0] reg_in,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    state_t      state;
    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic [15:0] oh_ra, oh_rb, oh_rc;
    logic        is_rtype, is_itype, is_alu, is_muldiv, is_ld, is_nop, is_halt;
    logic        step_done;
    logic        unused_ir_bits;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign unused_ir_bits = ^ir[14:0];

    assign is_rtype  = (opcode >= 5'b00011) && (opcode <= 5'b01100);
    assign is_itype  = (opcode >= 5'b01101) && (opcode <= 5'b01111);
    assign is_alu    = is_rtype || is_itype;
    assign is_muldiv = (opcode == 5'b10000) || (opcode == 5'b10001);
    assign is_ld     = (opcode == 5'b00000);
    assign is_nop    = (opcode == 5'b11010);
    assign is_halt   = (opcode == 5'b11011);

    // One-hot register selects for the three register fields
    for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
        assign oh_ra[gi] = (ra == 4'(gi));
        assign oh_rb[gi] = (rb == 4'(gi));
        assign oh_rc[gi] = (rc == 4'(gi));
    end

    // Flags the final step of the current instruction (halt never ends one);
    // unknown opcodes end at T3 like nop
    always_comb begin
        step_done = 1'b0;
        case (state)
            S_T3:    step_done = !(is_alu || is_muldiv || is_ld || is_halt);
            S_T5:    step_done = is_alu;
            S_T6:    step_done = !is_ld;
            S_T7:    step_done = 1'b1;
            default: step_done = 1'b0;
        endcase
    end

    // Step sequencing and completed-instruction counter
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            instr_count <= '0;
        end else if (step_done) begin
            instr_count <= instr_count + 16'd1;
            state       <= run ? S_T0 : S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (run) state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    if (mem_ready) state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3:    state <= is_halt ? S_HALT : S_T4;
                S_T4:    state <= S_T5;
                S_T5:    state <= S_T6;
                S_T6:    if (mem_ready) state <= S_T7;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Enable decode for the current step; everything not named stays low
    always_comb begin
        PCout    = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MDRout   = 1'b0;
        Cout     = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        ZHighIn  = 1'b0;
        ZLowIn   = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        reg_out  = '0;
        reg_in   = '0;
        alu_op   = '0;
        illegal  = 1'b0;
        busy     = (state != S_IDLE) && (state != S_HALT);
        halted   = (state == S_HALT);
        case (state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            S_T1: begin Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                if (is_alu || is_ld) begin
                    reg_out = oh_rb;
                    Yin     = 1'b1;
                end else if (is_muldiv) begin
                    reg_out = oh_ra;
                    Yin     = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    alu_op  = opcode;
                    ZLowIn  = 1'b1;
                    ZHighIn = 1'b1;
                    if (is_itype) Cout = 1'b1;
                    else          reg_out = oh_rc;
                end else if (is_muldiv) begin
                    reg_out = oh_rb;
                    alu_op  = opcode;
                    ZLowIn  = 1'b1;
                    ZHighIn = 1'b1;
                end else if (is_ld) begin
                    Cout   = 1'b1;
                    alu_op = ALU_ADD;
                    ZLowIn = 1'b1;
                end
            end
            S_T5: begin
                if (is_alu) begin
                    Zlowout = 1'b1;
                    reg_in  = oh_ra;
                end else if (is_muldiv) begin
                    Zlowout = 1'b1;
                    LOin    = 1'b1;
                end else if (is_ld) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end
            end
            S_T6: begin
                if (is_muldiv) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end else if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    reg_in = oh_ra;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction cases with
// literal expectations, then randomized run/mem_ready/ir/clear traffic
// compared every cycle against a step-table model of the sequencer.
module tb_control_sequencer;

    logic        clock, clear, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, Zhighout, Zlowout, MDRout, Cout;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
    logic        IncPC, Read;
    logic [15:0] reg_out, reg_in, instr_count;
    logic [4:0]  alu_op;
    logic        busy, halted, illegal;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
        .IncPC(IncPC), .Read(Read), .reg_out(reg_out), .reg_in(reg_in),
        .alu_op(alu_op), .busy(busy), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic PCout, Zhighout, Zlowout, MDRout, Cout;
        logic MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn;
        logic IncPC, Read;
        logic [15:0] reg_out, reg_in;
        logic [4:0]  alu_op;
        logic busy, halted, illegal;
    } ctl_t;

    ctl_t got;
    assign got = {PCout, Zhighout, Zlowout, MDRout, Cout,
                  MARin, PCin, MDRin, IRin, Yin, HIin, LOin, ZHighIn, ZLowIn,
                  IncPC, Read, reg_out, reg_in, alu_op, busy, halted, illegal};

    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    localparam int C_R = 0, C_I = 1, C_MD = 2, C_LD = 3, C_NOP = 4, C_HALT = 5, C_ILL = 6;

    int          checks = 0;
    int          failures = 0;
    int          m_mode, m_idx;
    logic [15:0] m_count;
    ctl_t        trace [0:15];
    int          tr_n, busy_n;

    // ---------------- behavioural model: instruction = list of steps ----------
    function automatic int plan_cls(input logic [31:0] i);
        logic [4:0] op = i[31:27];
        if (op >= 5'd3 && op <= 5'd12)   return C_R;
        if (op >= 5'd13 && op <= 5'd15)  return C_I;
        if (op == 5'd16 || op == 5'd17)  return C_MD;
        if (op == 5'd0)                  return C_LD;
        if (op == 5'd26)                 return C_NOP;
        if (op == 5'd27)                 return C_HALT;
        return C_ILL;
    endfunction

    function automatic int plan_len(input logic [31:0] i);
        case (plan_cls(i))
            C_R, C_I: return 6;
            C_MD:     return 7;
            C_LD:     return 8;
            default:  return 4;
        endcase
    endfunction

    function automatic bit plan_wait(input logic [31:0] i, input int idx);
        return (idx == 1) || (plan_cls(i) == C_LD && idx == 6);
    endfunction

    function automatic ctl_t plan_ctl(input logic [31:0] i, input int idx);
        ctl_t c = '0;
        int cls = plan_cls(i);
        logic [15:0] ra = 16'd1 << i[26:23];
        logic [15:0] rb = 16'd1 << i[22:19];
        logic [15:0] rc = 16'd1 << i[18:15];
        c.busy = 1'b1;
        if (idx == 0) begin c.PCout = 1; c.MARin = 1; c.IncPC = 1; end
        else if (idx == 1) begin c.Read = 1; c.MDRin = 1; end
        else if (idx == 2) begin c.MDRout = 1; c.IRin = 1; end
        else begin
            case (cls)
                C_R, C_I: begin
                    if (idx == 3) begin c.reg_out = rb; c.Yin = 1; end
                    if (idx == 4) begin
                        c.alu_op = i[31:27]; c.ZLowIn = 1; c.ZHighIn = 1;
                        if (cls == C_R) c.reg_out = rc; else c.Cout = 1;
                    end
                    if (idx == 5) begin c.Zlowout = 1; c.reg_in = ra; end
                end
                C_MD: begin
                    if (idx == 3) begin c.reg_out = ra; c.Yin = 1; end
                    if (idx == 4) begin c.reg_out = rb; c.alu_op = i[31:27]; c.ZLowIn = 1; c.ZHighIn = 1; end
                    if (idx == 5) begin c.Zlowout = 1; c.LOin = 1; end
                    if (idx == 6) begin c.Zhighout = 1; c.HIin = 1; end
                end
                C_LD: begin
                    if (idx == 3) begin c.reg_out = rb; c.Yin = 1; end
                    if (idx == 4) begin c.Cout = 1; c.alu_op = 5'b00011; c.ZLowIn = 1; end
                    if (idx == 5) begin c.Zlowout = 1; c.MARin = 1; end
                    if (idx == 6) begin c.Read = 1; c.MDRin = 1; end
                    if (idx == 7) begin c.MDRout = 1; c.reg_in = ra; end
                end
                C_ILL: c.illegal = 1;
                default: ;
            endcase
        end
        return c;
    endfunction

    function automatic ctl_t model_ctl();
        ctl_t c = '0;
        if (m_mode == M_HALT) c.halted = 1'b1;
        else if (m_mode == M_RUN) c = plan_ctl(ir, m_idx);
        return c;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_idx   = 0;
        m_count = '0;
    endtask

    task automatic model_step();
        if (!clear) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: if (run) begin m_mode = M_RUN; m_idx = 0; end
            M_RUN: begin
                if (!(plan_wait(ir, m_idx) && !mem_ready)) begin
                    if (m_idx == plan_len(ir) - 1) begin
                        if (plan_cls(ir) == C_HALT) m_mode = M_HALT;
                        else begin
                            m_count = m_count + 16'd1;
                            m_mode  = run ? M_RUN : M_IDLE;
                        end
                        m_idx = 0;
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic compare_model();
        ctl_t e = model_ctl();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL ctl t=%0t mode=%0d step=%0d got=%h exp=%h", $time, m_mode, m_idx, got, e);
        end
        checks++;
        if (instr_count !== m_count) begin
            failures++;
            $display("FAIL instr_count t=%0t got=%0d exp=%0d", $time, instr_count, m_count);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, a, e);
        end else begin
            $display("ok   %s = %h", name, a);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_model();
    endtask

    // Run one instruction from IDLE with run dropped after T0; t6_stall holds
    // mem_ready low that many cycles in a load's T6 wait
    task automatic run_one(input logic [31:0] i, input int t6_stall);
        int  stalls = 0;
        bit  done = 0;
        ir = i; run = 1'b1; mem_ready = 1'b1;
        tr_n = 0; busy_n = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            if (busy === 1'b1) busy_n++;
            if (m_mode == M_RUN) begin
                if (tr_n < 16) trace[tr_n] = got;
                tr_n++;
                run = 1'b0;
            end else if (tr_n > 0) begin
                done = 1;
            end
            mem_ready = !(m_mode == M_RUN && m_idx == 6 && plan_cls(ir) == C_LD && stalls < t6_stall);
            if (!mem_ready) stalls++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL run_one_timeout ir=%h got=busy exp=idle", i);
        end
        $display("instr ir=%h clocks=%0d count=%0d", i, busy_n, instr_count);
    endtask

    task automatic async_clear();
        #2 clear = 1'b0;
        #1 model_reset();
        compare_model();
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        int r = $urandom_range(0, 15);
        if (r < 6)       op = 5'($urandom_range(3, 12));
        else if (r < 8)  op = 5'($urandom_range(13, 15));
        else if (r < 10) op = 5'($urandom_range(16, 17));
        else if (r < 12) op = 5'd0;
        else if (r == 12) op = 5'd26;
        else if (r == 13) op = (($urandom % 4) == 0) ? 5'd27 : 5'd26;
        else             op = 5'($urandom);
        return {op, 27'($urandom)};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int rd;
        int ill_n;
        int hc;
        bit rel;
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;
        model_reset();
        @(negedge clock);
        compare_model();
        chk("reset_outputs", 64'(got), 64'h0);
        chk("reset_count", 64'(instr_count), 64'd0);
        clear = 1'b1;
        tick();
        tick();
        chk("idle_no_run", 64'(got), 64'h0);

        // add R1,R2,R3
        run_one(32'h1891_8000, 0);
        chk("add_clocks", 64'(busy_n), 64'd6);
        chk("add_t3", {trace[3].reg_out, trace[3].Yin}, {16'h0004, 1'b1});
        chk("add_t4", {trace[4].reg_out, trace[4].alu_op, trace[4].ZLowIn}, {16'h0008, 5'b00011, 1'b1});
        chk("add_t5", {trace[5].reg_in, trace[5].Zlowout}, {16'h0002, 1'b1});
        chk("add_count", 64'(instr_count), 64'd1);

        // ld R4,0x10(R5) with three stall cycles in T6
        run_one({5'b00000, 4'd4, 4'd5, 4'd0, 15'h0010}, 3);
        rd = 0;
        for (int k = 3; k < tr_n && k < 16; k++) if (trace[k].Read) rd++;
        chk("ld_clocks", 64'(busy_n), 64'd11);
        chk("ld_read_t6", 64'(rd), 64'd4);
        chk("ld_t7", {trace[10].reg_in, trace[10].MDRout}, {16'h0010, 1'b1});
        chk("ld_count", 64'(instr_count), 64'd2);

        // mul R6,R7
        run_one({5'b10000, 4'd6, 4'd7, 4'd0, 15'd0}, 0);
        chk("mul_clocks", 64'(busy_n), 64'd7);
        chk("mul_t3", 64'(trace[3].reg_out), 64'h0040);
        chk("mul_t5", {trace[5].LOin, trace[5].Zlowout, trace[5].HIin}, 64'b110);
        chk("mul_t6", {trace[6].HIin, trace[6].Zhighout, trace[6].LOin}, 64'b110);

        // nop
        run_one({5'b11010, 27'd0}, 0);
        chk("nop_clocks", 64'(busy_n), 64'd4);

        // illegal opcode 11111
        run_one({5'b11111, 27'h5A5_A5A5}, 0);
        ill_n = 0;
        for (int k = 0; k < tr_n && k < 16; k++) if (trace[k].illegal) ill_n++;
        chk("ill_pulses", 64'(ill_n), 64'd1);
        chk("ill_t3", 64'(trace[3].illegal), 64'd1);
        chk("ill_count", 64'(instr_count), 64'd5);

        // halt, then run held high for 20 clocks
        run_one({5'b11011, 27'd0}, 0);
        run = 1'b1;
        for (int k = 0; k < 20; k++) tick();
        chk("halt_state", 64'(got), 64'h2);
        chk("halt_count", 64'(instr_count), 64'd5);
        async_clear();
        chk("clear_outputs", 64'(got), 64'h0);
        chk("clear_count", 64'(instr_count), 64'd0);
        run = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        tick();

        // first fetch after clear, then reset mid-T4 of a second add
        run_one(32'h1891_8000, 0);
        chk("post_clear_t0", {trace[0].PCout, trace[0].MARin, trace[0].IncPC, trace[0].busy}, 64'hF);
        chk("post_clear_count", 64'(instr_count), 64'd1);
        run = 1'b1;
        for (int k = 0; k < 12 && !(m_mode == M_RUN && m_idx == 4); k++) tick();
        chk("reach_t4", 64'(got.ZLowIn), 64'd1);
        async_clear();
        chk("t4_clear_outputs", 64'(got), 64'h0);
        chk("t4_clear_count", 64'(instr_count), 64'd0);
        run = 1'b0;
        tick();
        clear = 1'b1;
        tick();

        // randomized traffic against the model
        hc = 0;
        rel = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (rel) begin clear = 1'b1; rel = 0; end
            run       = ($urandom % 10) < 8;
            mem_ready = ($urandom % 10) < 7;
            if ((m_mode != M_RUN || m_idx <= 2) && ($urandom % 3) == 0) ir = rand_ir();
            if (m_mode == M_HALT) hc++;
            else hc = 0;
            if (clear && (hc > 6 || ($urandom % 300) == 0)) begin
                async_clear();
                rel = 1;
                hc = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
